car_id_store_ctrl: RTL and testbench

//  Controller for the car-ID table: samples the 5-digit BCD keypad/decoder word on a divided tick,

---
 rtl/car_id_pkg.sv | 16 +
 rtl/car_id_regfile.sv | 28 ++
 rtl/car_id_store_ctrl.sv | 162 ++++++++++++++++
 tb/tb_car_id_store_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/car_id_pkg.sv
// Shared types and helpers for the car-ID table controller.
package car_id_pkg;

  localparam int CAR_ID_W = 20;

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, WRITE = 2'd2} car_id_state_e;

  // Table stores the first keyed digit in the top nibble.
  function automatic logic [CAR_ID_W-1:0] nib_rev(input logic [CAR_ID_W-1:0] d);
    logic [CAR_ID_W-1:0] r;
    r = '0;
    for (int i = 0; i < CAR_ID_W/4; i++) r[CAR_ID_W-4-4*i +: 4] = d[4*i +: 4];
    return r;
  endfunction

endpackage

// File: rtl/car_id_regfile.sv
// Car-ID storage: DEPTH x W, one synchronous write port, one registered read port.
module car_id_regfile #(
  parameter int DEPTH = 20,
  parameter int W     = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [4:0]   waddr,
  input  logic [W-1:0] wdata,
  input  logic         re,
  input  logic [4:0]   raddr,
  output logic [W-1:0] rdata
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] LIM = 5'(DEPTH);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we && waddr < LIM) mem[waddr[AW-1:0]] <= wdata;

  // Read-before-write: a same-cycle write to raddr returns the old word.
  always_ff @(posedge clk or posedge rst)
    if (rst)     rdata <= '0;
    else if (re) rdata <= (raddr < LIM) ? mem[raddr[AW-1:0]] : '0;

endmodule

// File: rtl/car_id_store_ctrl.sv
// Car-ID table controller: tick-sampled debounce, table write FSM, bus/display read arbiter.
// Optional build macro CAR_ID_DUP_FILTER_EN adds a duplicate scan of the table before each write.
module car_id_store_ctrl
  import car_id_pkg::*;
#(
  parameter int DEPTH    = 20,
  parameter int DIGITS   = 5,
  parameter int TICK_DIV = 6_000_000,
  parameter int STABLE_N = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] digit,
  input  logic                clr,
  input  logic                bus_req,
  input  logic [4:0]          bus_idx,
  output logic                bus_gnt,
  input  logic                disp_req,
  input  logic [4:0]          disp_idx,
  output logic                disp_gnt,
  output logic [4*DIGITS-1:0] rd_data,
  output logic                rd_valid,
  output logic                rd_err,
  output logic [4:0]          count,
  output logic                done,
  output logic                ovf
);
  localparam int W  = 4*DIGITS;
  localparam int CW = $clog2(TICK_DIV);
  localparam int SW = $clog2(STABLE_N+1);
  localparam logic [4:0]    FULL      = 5'(DEPTH);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV-1);
  localparam logic [SW-1:0] STAB_N    = SW'(STABLE_N);
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_CHECK = CHECK;
  localparam logic [1:0] ST_WRITE = WRITE;
`ifdef CAR_ID_DUP_FILTER_EN
  localparam bit DUP_FILTER = 1'b1;
`else
  localparam bit DUP_FILTER = 1'b0;
`endif

  logic [CW-1:0] tick_cnt;
  logic          tick, pend, hit, scan_rd, any_gnt, rf_re, rf_we;
  logic [SW-1:0] stab, stab_nxt;
  logic [W-1:0]  prev, last_written, pend_id, cur_id, cur_rev, rf_q;
  logic [1:0]    st;
  logic [4:0]    scan_idx, scan_nxt, gnt_idx, rf_raddr;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge rst)
    if (rst) tick_cnt <= '0;
    else     tick_cnt <= tick ? '0 : tick_cnt + CW'(1);

  always_comb begin
    stab_nxt = stab;
    if (digit == '0)                stab_nxt = '0;
    else if (digit != prev)         stab_nxt = SW'(1);
    else if (stab != STAB_N)        stab_nxt = stab + SW'(1);
  end

  // One candidate per stable run: fire only on the tick the run first reaches STABLE_N.
  assign hit = tick && (digit != '0) && (stab_nxt == STAB_N) &&
               !(digit == prev && stab == STAB_N) && (digit != last_written);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prev <= '0;
      stab <= '0;
    end else if (tick) begin
      prev <= digit;
      stab <= stab_nxt;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend    <= 1'b0;
      pend_id <= '0;
    end else if (clr) begin
      pend    <= 1'b0;
    end else if (hit) begin
      pend    <= 1'b1;
      pend_id <= digit;
    end else if (st == ST_IDLE) begin
      pend    <= 1'b0;
    end

  always_comb begin
    cur_rev = '0;
    for (int i = 0; i < DIGITS; i++) cur_rev[4*(DIGITS-1-i) +: 4] = cur_id[4*i +: 4];
  end

  // Duplicate scan owns the read port: entry 0 is fetched from IDLE, the rest one per CHECK cycle.
  assign scan_nxt = scan_idx + 5'd1;
  assign scan_rd  = DUP_FILTER && (count != '0) &&
                    ((st == ST_IDLE && pend) || (st == ST_CHECK && scan_nxt < count));
  assign bus_gnt  = !rst && bus_req && !scan_rd;
  assign disp_gnt = !rst && disp_req && !bus_req && !scan_rd;
  assign any_gnt  = bus_gnt | disp_gnt;
  assign gnt_idx  = bus_req ? bus_idx : disp_idx;
  assign rf_re    = scan_rd | any_gnt;
  assign rf_raddr = scan_rd ? ((st == ST_CHECK) ? scan_nxt : 5'd0) : gnt_idx;
  assign rf_we    = (st == ST_WRITE) && !clr && (count < FULL);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= ST_IDLE; cur_id <= '0; scan_idx <= '0;
      count <= '0; done <= 1'b0; ovf <= 1'b0; last_written <= '0;
    end else if (clr) begin
      st <= ST_IDLE;
      count <= '0; done <= 1'b0; ovf <= 1'b0; last_written <= '0;
    end else begin
      case (st)
        ST_IDLE:
          if (pend) begin
            cur_id   <= pend_id;
            scan_idx <= '0;
            st       <= ST_CHECK;
          end
        ST_CHECK:
          if (!DUP_FILTER || count == '0) st <= ST_WRITE;
          else if (rf_q == cur_rev)       st <= ST_IDLE;
          else if (scan_nxt >= count)     st <= ST_WRITE;
          else                            scan_idx <= scan_nxt;
        ST_WRITE: begin
          if (count < FULL) begin
            count <= count + 5'd1;
            if (count == FULL - 5'd1) done <= 1'b1;
          end else begin
            ovf <= 1'b1;
          end
          last_written <= cur_id;
          st <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= any_gnt;
      rd_err   <= any_gnt && (gnt_idx >= count);
    end

  assign rd_data = (rd_valid && !rd_err) ? rf_q : '0;

  car_id_regfile #(.DEPTH(DEPTH), .W(W)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (rf_we),
    .waddr (count),
    .wdata (cur_rev),
    .re    (rf_re),
    .raddr (rf_raddr),
    .rdata (rf_q)
  );

endmodule

// File: tb/tb_car_id_store_ctrl.sv
// Bench for car_id_store_ctrl: vector table, hand sequences, and random stimulus against a run-length model.
module tb_car_id_store_ctrl;
  localparam int DEPTH = 4, DIGITS = 5, TICK_DIV = 4, STABLE_N = 2, W = 20;

  logic clk = 1'b0;
  logic rst, clr, bus_req, disp_req, bus_gnt, disp_gnt, rd_valid, rd_err, done, ovf;
  logic [W-1:0] digit, rd_data;
  logic [4:0] bus_idx, disp_idx, count;
  int n_vec = 0, n_err = 0;

  logic [W-1:0] m_tab[$];
  logic [W-1:0] m_last, m_rv;
  int  m_run;
  bit  m_ovf;

  typedef struct {
    logic [W-1:0] d;
    int           n;
    logic [4:0]   cnt;
    logic         dn;
    logic         ov;
  } vec_t;

  always #5 clk = ~clk;

  car_id_store_ctrl #(.DEPTH(DEPTH), .DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .STABLE_N(STABLE_N)) dut (
    .clk(clk), .rst(rst), .digit(digit), .clr(clr),
    .bus_req(bus_req), .bus_idx(bus_idx), .bus_gnt(bus_gnt),
    .disp_req(disp_req), .disp_idx(disp_idx), .disp_gnt(disp_gnt),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
    .count(count), .done(done), .ovf(ovf)
  );

  function automatic logic [W-1:0] rev(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) r = (r << 4) | ((d >> (4*i)) & 20'hF);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_tab.delete(); m_last = '0; m_rv = '0; m_run = 0; m_ovf = 0;
  endtask

  task automatic m_clr();
    m_tab.delete(); m_last = '0; m_ovf = 0;
  endtask

  // Accept when a non-zero value has been seen exactly STABLE_N ticks in a row.
  task automatic m_sample(input logic [W-1:0] d);
    bit dup;
    if (d == '0) begin m_run = 0; m_rv = '0; end
    else if (d == m_rv) m_run++;
    else begin m_run = 1; m_rv = d; end
    if (d != '0 && m_run == STABLE_N && d != m_last) begin
      dup = 0;
`ifdef CAR_ID_DUP_FILTER_EN
      foreach (m_tab[i]) if (m_tab[i] == rev(d)) dup = 1;
`endif
      if (!dup) begin
        if (m_tab.size() < DEPTH) m_tab.push_back(rev(d));
        else m_ovf = 1;
        m_last = d;
      end
    end
  endtask

  // Each window spans TICK_DIV rising edges, so it contains exactly one sample tick.
  task automatic apply(input logic [W-1:0] d, input int n);
    for (int k = 0; k < n; k++) begin
      digit = d;
      repeat (TICK_DIV) @(negedge clk);
      m_sample(d);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; digit = '0; clr = 0; bus_req = 0; disp_req = 0; bus_idx = '0; disp_idx = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    m_reset();
  endtask

  task automatic do_clr();
    clr = 1;
    @(negedge clk);
    clr = 0;
    m_clr();
  endtask

  task automatic do_read(input bit bus, input logic [4:0] idx,
                         output logic v, output logic e, output logic [W-1:0] d);
    int n;
    n = 0;
    if (bus) begin bus_req = 1; bus_idx = idx; end
    else     begin disp_req = 1; disp_idx = idx; end
    #1;
    while (!(bus ? bus_gnt : disp_gnt) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) begin
      n_vec++; n_err++;
      $display("FAIL rd_gnt_timeout: no grant for idx %0d", idx);
      bus_req = 0; disp_req = 0; v = 0; e = 0; d = '0;
      @(negedge clk);
      return;
    end
    @(posedge clk); #1;
    bus_req = 0; disp_req = 0;
    v = rd_valid; e = rd_err; d = rd_data;
    @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[8];
    logic [W-1:0] ent[4];
    logic [W-1:0] pool[7];
    logic v, e;
    logic [W-1:0] d, rd;
    logic [4:0] idx;
    bit b;
    int h;

    vt[0] = '{20'h12345, 4, 5'd1, 1'b0, 1'b0};
    vt[1] = '{20'h00000, 2, 5'd1, 1'b0, 1'b0};
    vt[2] = '{20'h12345, 4, 5'd1, 1'b0, 1'b0};
    vt[3] = '{20'h11111, 1, 5'd1, 1'b0, 1'b0};
    vt[4] = '{20'h67890, 4, 5'd2, 1'b0, 1'b0};
    vt[5] = '{20'h13579, 4, 5'd3, 1'b0, 1'b0};
    vt[6] = '{20'h24680, 4, 5'd4, 1'b1, 1'b0};
    vt[7] = '{20'h55555, 4, 5'd4, 1'b1, 1'b1};
    ent   = '{20'h54321, 20'h09876, 20'h97531, 20'h08642};
    pool  = '{20'h0, 20'h12345, 20'h67890, 20'h13579, 20'h24680, 20'h11111, 20'h98765};

    rst = 1; clr = 0; digit = '0; bus_req = 0; disp_req = 0; bus_idx = '0; disp_idx = '0;
    do_reset();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_err", 32'(rd_err), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_gnts", 32'({bus_gnt, disp_gnt}), 32'd0);

    // Ticks land on edges 4 and 8 after release; the write state spans edges 10..11.
    digit = 20'h31415;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rstw_count", 32'(count), 32'd0);
    chk("rstw_flags", 32'({done, ovf, rd_valid}), 32'd0);
    rst = 0;
    m_reset();
    apply(20'h27182, 4);
    chk("rstw_next_count", 32'(count), 32'd1);
    do_read(1'b1, 5'd0, v, e, rd);
    chk("rstw_entry0", 32'(rd), 32'h28172);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(vt[i].d, vt[i].n);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].cnt));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vt[i].dn));
      chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vt[i].ov));
    end
    for (int i = 0; i < 4; i++) begin
      do_read(i[0], 5'(i), v, e, rd);
      chk($sformatf("entry%0d", i), 32'(rd), 32'(ent[i]));
      chk($sformatf("entry%0d_vld", i), 32'({v, e}), 32'b10);
    end

    bus_req = 1; bus_idx = 5'd0; disp_req = 1; disp_idx = 5'd1;
    #1;
    chk("arb_bus_first", 32'({bus_gnt, disp_gnt}), 32'b10);
    @(posedge clk); #1;
    bus_req = 0;
    #1;
    chk("arb_disp_next", 32'({bus_gnt, disp_gnt}), 32'b01);
    chk("arb_rd0", 32'({rd_valid, rd_data}), 32'({1'b1, 20'h54321}));
    @(posedge clk); #1;
    disp_req = 0;
    chk("arb_rd1", 32'({rd_valid, rd_data}), 32'({1'b1, 20'h09876}));
    @(negedge clk);

    do_clr();
    chk("clr_state", 32'({count, done, ovf}), 32'd0);

    apply(20'h12345, 4);
    apply(20'h67890, 4);
    chk("two_count", 32'(count), 32'd2);
    do_read(1'b1, 5'd7, v, e, rd);
    chk("oob_flags", 32'({v, e}), 32'b11);
    chk("oob_data", 32'(rd), 32'd0);
    do_read(1'b0, 5'd1, v, e, rd);
    chk("idx1_data", 32'({e, rd}), 32'h09876);

    apply(20'h12345, 4);
`ifdef CAR_ID_DUP_FILTER_EN
    chk("dup_count", 32'(count), 32'd2);
`else
    chk("dup_count", 32'(count), 32'd3);
`endif

    do_reset();
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 7) == 0) do_clr();
      d = pool[$urandom_range(0, 6)];
      h = int'($urandom_range(1, 3));
      apply(d, h);
      apply(20'h0, 2);
      chk($sformatf("rnd%0d_count", s), 32'(count), 32'(m_tab.size()));
      chk($sformatf("rnd%0d_flags", s), 32'({done, ovf}), 32'({m_tab.size() == DEPTH, m_ovf}));
      idx = 5'($urandom_range(0, 5));
      b = 1'($urandom_range(0, 1));
      do_read(b, idx, v, e, rd);
      if (int'(idx) < m_tab.size())
        chk($sformatf("rnd%0d_rd", s), 32'({v, e, rd}), 32'({1'b1, 1'b0, m_tab[idx]}));
      else
        chk($sformatf("rnd%0d_rd", s), 32'({v, e, rd}), 32'({1'b1, 1'b1, 20'h0}));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
